// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter and its bench.
package rr_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Why a grant ended; REL_NONE marks cycles with no release.
  typedef enum logic [1:0] {
    REL_NONE  = 2'd0,
    REL_DONE  = 2'd1,
    REL_ABORT = 2'd2,
    REL_TMO   = 2'd3
  } rel_e;

  function automatic logic [N_REQ-1:0] idxToOneHot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick4
  import rr_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] pick_o
);

  // Walk the search order backwards so the candidate nearest ptr wins last.
  always_comb begin
    valid_o = |req_i;
    pick_o  = ptr_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[ptr_i + IDX_W'(k)]) pick_o = ptr_i + IDX_W'(k);
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with done/abort/hold-timeout release of the grant.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk1,
  input  logic                 clr,
  input  logic [N_REQ-1:0]     req,
  input  logic                 done,
  output logic [N_REQ-1:0]     grant,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam bit              TMO_EN    = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   grantId_q, grantId_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   holdCnt_q, holdCnt_d;
  logic               timeout_q, timeout_d;

  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pickValid),
    .pick_o  (pickIdx)
  );

  // Next-state logic: grant from IDLE, release from BUSY in done > abort > timeout order.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    grantId_d = grantId_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pickValid) begin
          state_d   = ST_BUSY;
          grant_d   = idxToOneHot(pickIdx);
          grantId_d = pickIdx;
          holdCnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (done || !req[grantId_q] || (TMO_EN && (holdCnt_q == HOLD_LAST))) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          ptr_d     = grantId_q + IDX_W'(1);
          timeout_d = !done && req[grantId_q];
        end else if (holdCnt_q != CNT_MAX) begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State registers; clr drops any grant immediately without a timeout pulse.
  always_ff @(posedge clk1) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      grantId_q <= '0;
      ptr_q     <= '0;
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      grantId_q <= grantId_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grantId_q;
  assign busy     = |grant_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: vector table, hand sequences, invariants.
module tb_rr_arbiter_4;
  import rr_arbiter_4_pkg::*;

  localparam int MAX_HOLD = 8;

  logic       clk1 = 1'b0;
  logic       clr  = 1'b1;
  logic [3:0] req  = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int total  = 0;
  int bad    = 0;
  int stepNo = 0;
  bit invOn  = 1'b0;

  typedef struct {
    logic       clr;
    logic [3:0] req;
    logic       done;
    logic [3:0] expGrant;
    logic [1:0] expId;
    rel_e       cause;
  } vec_t;

  typedef struct {
    int         step;
    logic [3:0] expGrant;
    logic [1:0] expId;
    rel_e       cause;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[21];

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk1     (clk1),
    .clr      (clr),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  // Free-running clock.
  always #5 clk1 = ~clk1;

  // Structural invariants on every falling edge once reset has been applied.
  always @(negedge clk1) begin
    if (invOn) begin
      total++;
      if (!$onehot0(grant)) begin
        bad++;
        $display("[TB] FAIL onehot0: grant=%b is not one-hot or zero", grant);
      end
      total++;
      if (busy !== (|grant)) begin
        bad++;
        $display("[TB] FAIL busy_eq: busy=%b but |grant=%b", busy, |grant);
      end
    end
  end

  // Hard stop so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic c, input logic [3:0] r, input logic d,
                              input logic [3:0] g, input logic [1:0] id, input rel_e cause);
    vec_t v;
    v.clr      = c;
    v.req      = r;
    v.done     = d;
    v.expGrant = g;
    v.expId    = id;
    v.cause    = cause;
    return v;
  endfunction

  task automatic checkField(input string name, input int step,
                            input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL step %0d %s: got %b expected %b", step, name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: no expectation queued, got grant=%b", grant);
    end else begin
      e = expQ.pop_front();
      checkField("grant",    e.step, grant,                  e.expGrant);
      checkField("grant_id", e.step, {2'b00, grant_id},      {2'b00, e.expId});
      checkField("busy",     e.step, {3'b000, busy},         {3'b000, e.expGrant != 4'b0000});
      checkField("timeout",  e.step, {3'b000, timeout},      {3'b000, e.cause == REL_TMO});
    end
  endtask

  task automatic applyStimulus(input logic c, input logic [3:0] r, input logic d,
                               input logic [3:0] g, input logic [1:0] id, input rel_e cause);
    exp_t e;
    clr  = c;
    req  = r;
    done = d;
    stepNo++;
    e.step     = stepNo;
    e.expGrant = g;
    e.expId    = id;
    e.cause    = cause;
    expQ.push_back(e);
    @(posedge clk1);
    @(negedge clk1);
    checkOutput();
  endtask

  // Main sequence: vector table, then timeout, done-vs-timeout and fairness runs.
  initial begin
    // reset and idle behaviour, done ignored while idle
    vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, REL_NONE);
    vecs[1]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, REL_NONE);
    vecs[2]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, REL_NONE);
    // basic rotation with ptr wrap 3 -> 0
    vecs[3]  = mk(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, REL_NONE);
    vecs[4]  = mk(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, REL_NONE);
    vecs[5]  = mk(1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, REL_DONE);
    vecs[6]  = mk(1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, REL_NONE);
    vecs[7]  = mk(1'b0, 4'b1010, 1'b1, 4'b0000, 2'd3, REL_DONE);
    vecs[8]  = mk(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, REL_NONE);
    vecs[9]  = mk(1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, REL_DONE);
    // non-owner toggling ignored, owner drop aborts, other requester next
    vecs[10] = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, REL_NONE);
    vecs[11] = mk(1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, REL_NONE);
    vecs[12] = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, REL_NONE);
    vecs[13] = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 2'd2, REL_ABORT);
    vecs[14] = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, REL_NONE);
    vecs[15] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, REL_ABORT);
    // clr mid-grant drops grant, clears id and ptr, no timeout
    vecs[16] = mk(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, REL_NONE);
    vecs[17] = mk(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, REL_NONE);
    vecs[18] = mk(1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, REL_NONE);
    vecs[19] = mk(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, REL_NONE);
    vecs[20] = mk(1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, REL_DONE);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].req, vecs[i].done,
                    vecs[i].expGrant, vecs[i].expId, vecs[i].cause);
      invOn = 1'b1;
    end

    // hold timeout: ptr=2, requester 0 holds for exactly MAX_HOLD cycles
    for (int i = 0; i < MAX_HOLD; i++)
      applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, REL_NONE);
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, REL_TMO);
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, REL_NONE);
    applyStimulus(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, REL_DONE);

    // done on the cycle the timeout would fire: done wins, no pulse
    applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, REL_NONE);
    for (int i = 1; i < MAX_HOLD; i++)
      applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, REL_NONE);
    applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, REL_DONE);

    // full load from ptr=2: each requester in turn, one idle cycle between
    for (int i = 0; i < 5; i++) begin
      logic [1:0] who;
      who = 2'(2 + i);
      applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0001 << who, who, REL_NONE);
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0000, who, REL_DONE);
    end

    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, REL_NONE);

    invOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
Round-robin arbiter that shares one counter/datapath resource between four requesters.
- Registered one-hot grant plus a 2-bit grant index, so grant_id can drive the resource's select/clear directly.
- Grant is held until the owner signals done, the owner drops its request, or a hold-timeout forces release.
- Sits between the requesting control blocks and the shared 2-bit counter datapath.

Parameters:
MAX_HOLD, 8, max cycles a grant may be held before forced release; 0 disables timeout
CNT_W, 4, width of hold counter; must satisfy MAX_HOLD < 2**CNT_W

Ports:
clk1  input  1  system clock, rising-edge
clr  input  1  synchronous, active-high reset; sampled on posedge clk1
req  input  4  request per requester, level, bit i = requester i
done  input  1  current owner finished; sampled only while busy
grant  output  4  one-hot registered grant; 4'b0000 when idle
grant_id  output  2  index of granted requester; holds last value when idle
busy  output  1  1 while any grant is asserted
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset: clr=1 at a clk1 edge forces state=IDLE, grant=4'b0000, grant_id=2'b00, busy=0, timeout=0, ptr=2'b00, hold_cnt=0. clr overrides every other input; asserting it mid-grant drops the grant at that edge with no timeout pulse.
- ptr: 2-bit round-robin pointer, the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4; wrap 3->0 is natural 2-bit overflow.
- State IDLE (grant=0, busy=0):
  - If req!=0 at an edge, pick the first set bit in search order.
  - At that edge: grant=onehot(pick), grant_id=pick, busy=1, hold_cnt=0, state=BUSY.
  - Latency: req high at edge N gives grant visible from edge N to N+1.
  - done in IDLE is ignored.
- State BUSY, evaluated each edge in priority order:
  1. done=1: release. grant=0, busy=0, ptr=grant_id+1, state=IDLE, timeout=0.
  2. req[grant_id]=0: abort release. Same as done, timeout=0.
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: forced release. Same as done, but timeout=1.
  4. Otherwise hold: hold_cnt+=1 (saturating at 2**CNT_W-1 when MAX_HOLD=0); grant unchanged.
- Grant is held for at most MAX_HOLD cycles.
- timeout is high exactly one cycle (the first IDLE cycle) and clears at the next edge.
- Minimum one idle cycle between consecutive grants, even with continuous requests.
- Simultaneous done and timeout condition: done wins, timeout=0.
- Changes on req bits other than the owner's have no effect during BUSY.
- Fairness: a continuously requesting requester is granted within 3 other grants.
- grant is always one-hot or zero. busy == |grant at all times.

Decomposition:
- Shared package holds:
  - N_REQ=4 and IDX_W=2.
  - State encoding localparams ST_IDLE=1'b0 and ST_BUSY=1'b1.
  - Release-cause encodings (REL_DONE, REL_ABORT, REL_TMO), used by the bench scoreboard.
- One natural sub-module: rr_pick4.
  - Combinational, inputs req[3:0] and ptr[1:0].
  - Outputs valid and pick[1:0].
  - Instantiated once. All registers stay in rr_arbiter_4.

Test Plan:
- Reset then idle: clr=1 for 2 cycles, req=0 -> grant=0000, grant_id=00, busy=0, timeout=0. Apply clr=1 mid-grant -> grant=0000 at that edge, timeout stays 0.
- Basic rotation: ptr=0, req=1010 -> grant=0010, id=1. done after 2 cycles -> grant=0000 next edge, ptr=2. req=1010 -> grant=1000, id=3. done -> ptr wraps to 0. req=1010 -> grant=0010.
- Timeout (MAX_HOLD=8): req=0001 held, done=0 -> grant=0001 for exactly 8 cycles, then grant=0000 with timeout=1 for one cycle. Next edge: grant=0001 again if no other req (ptr=1, search finds 0).
- Fairness under full load: req=1111 constantly, done pulsed 1 cycle after each grant -> grant sequence 0001,0010,0100,1000,0001 with one idle cycle between each.
- Simultaneous events (MAX_HOLD=4): done=1 on the 4th held cycle -> release with timeout=0. Owner drops req while req[other]=1 -> grant=0000 next edge, timeout=0, then the other requester is granted.
- Ignored inputs: done=1 while idle -> no state change. Non-owner req toggling during BUSY -> grant unchanged. Invariant checked every cycle: $onehot0(grant) and busy==|grant.
